// File: rtl/histogram_axi_banked_if.sv
// AXI4-Lite read channel used by the histogram peripheral. The peripheral
// takes the slave modport and the CPU side takes the master modport.
interface histogram_axi_banked_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave  (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
    modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
endinterface

// File: rtl/histogram_axi_banked.sv
// Per-frame luma histogram with saturating bins and a frame pixel total.
// Results are read over AXI4-Lite. Bin reads return SLVERR while the RAM is owned by the pipeline.
module histogram_axi_banked #(
    parameter int PIX_W    = 8,
    parameter int BIN_BITS = 8,
    parameter int CNT_W    = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     y_i,
    input  logic                 dv_i,
    input  logic                 vs_i,
    input  logic                 cpu_trigger,
    output logic                 cpu_signal_done,
    histogram_axi_banked_if.slave axi
);
    localparam int NBINS = 1 << BIN_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, ARMED = 2'd2, ACCUM = 2'd3} state_t;

    state_t              state_q, state_d;
    logic                done_q;
    logic                vs_q, vs_edge;
    logic                draining, drain_last;
    logic [1:0]          drain_cnt;
    logic [BIN_BITS-1:0] clr_idx;

    logic                accept;
    logic [1:0]          vld_pipe;
    logic [BIN_BITS-1:0] p1_bin, p2_bin;
    logic [31:0]         total;

    logic [CNT_W-1:0]    mem [NBINS];
    logic [CNT_W-1:0]    ram_q;
    logic                wr_en;
    logic [BIN_BITS-1:0] wr_addr, rd_addr;
    logic [CNT_W-1:0]    wr_data;

    logic                ar_hs, pend, err_q, reg_q;
    logic [BIN_BITS-1:0] word_q;
    logic [31:0]         rd_word;

    assign cpu_signal_done = done_q;
    assign drain_last      = draining && (drain_cnt == 2'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_trigger) state_d = CLEAR;
            CLEAR:   if (clr_idx == '1) state_d = ARMED;
            ARMED:   if (vs_edge) state_d = ACCUM;
            ACCUM:   if (drain_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // After the closing vs edge ACCUM is held two more cycles so the last
    // pixel's write lands before done rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            vs_q      <= 1'b0;
            vs_edge   <= 1'b0;
            clr_idx   <= '0;
            draining  <= 1'b0;
            drain_cnt <= 2'd0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_i;
            vs_edge <= vs_i & ~vs_q;
            clr_idx <= (state_q == CLEAR) ? clr_idx + 1'b1 : '0;
            if (state_q == IDLE && cpu_trigger)
                done_q <= 1'b0;
            else if (drain_last)
                done_q <= 1'b1;
            if (state_q == ACCUM && !draining && vs_edge) begin
                draining  <= 1'b1;
                drain_cnt <= 2'd2;
            end else if (draining) begin
                drain_cnt <= drain_cnt - 2'd1;
                if (drain_last) draining <= 1'b0;
            end
        end
    end

    assign accept = (state_q == ACCUM) && !draining && !vs_edge && dv_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= 2'b00;
            p1_bin   <= '0;
            p2_bin   <= '0;
            total    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            p1_bin   <= y_i[PIX_W-1 -: BIN_BITS];
            p2_bin   <= p1_bin;
            if (state_q == CLEAR)
                total <= '0;
            else if (accept && total != '1)
                total <= total + 32'd1;
        end
    end

    always_comb begin
        wr_en   = (state_q == CLEAR) || vld_pipe[1];
        wr_addr = (state_q == CLEAR) ? clr_idx : p2_bin;
        wr_data = '0;
        if (state_q != CLEAR)
            wr_data = (ram_q == CNT_MAX) ? ram_q : ram_q + 1'b1;
        rd_addr = (state_q == ACCUM) ? p1_bin : axi.araddr[BIN_BITS+1:2];
    end

    // Write-first bypass covers a same-bin pixel one cycle behind; older
    // writes are already in the array when the read happens.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        ram_q <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
    end

    assign ar_hs = axi.arvalid && axi.arready;

    always_comb begin
        rd_word = 32'(ram_q);
        if (err_q)
            rd_word = '0;
        else if (reg_q) begin
            if (word_q == '0)
                rd_word = total;
            else if (word_q == BIN_BITS'(1))
                rd_word = {29'b0, state_q, done_q};
            else
                rd_word = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axi.arready <= 1'b1;
            axi.rvalid  <= 1'b0;
            axi.rdata   <= '0;
            axi.rresp   <= 2'b00;
            pend        <= 1'b0;
            err_q       <= 1'b0;
            reg_q       <= 1'b0;
            word_q      <= '0;
        end else begin
            if (ar_hs) begin
                axi.arready <= 1'b0;
                pend        <= 1'b1;
                reg_q       <= axi.araddr[BIN_BITS+2];
                word_q      <= axi.araddr[BIN_BITS+1:2];
                err_q       <= !axi.araddr[BIN_BITS+2] && (state_q == CLEAR || state_q == ACCUM);
            end
            if (pend) begin
                pend       <= 1'b0;
                axi.rvalid <= 1'b1;
                axi.rdata  <= rd_word;
                axi.rresp  <= err_q ? 2'b10 : 2'b00;
            end
            if (axi.rvalid && axi.rready) begin
                axi.rvalid  <= 1'b0;
                axi.arready <= 1'b1;
            end
        end
    end

    logic unused_addr;
    assign unused_addr = ^{axi.araddr[31:BIN_BITS+3], axi.araddr[1:0]};

    generate
        if (PIX_W > BIN_BITS) begin : g_low_pix
            logic unused_pix;
            assign unused_pix = ^y_i[PIX_W-BIN_BITS-1:0];
        end
    endgenerate
endmodule

// File: tb/tb_histogram_axi_banked.sv
// Bench for histogram_axi_banked: a 256-bin/24-bit instance and a 16-bin/4-bit instance share the pixel stream.
// Both are checked against an array model of the histogram.
module tb_histogram_axi_banked;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] y   = '0;
    logic       dv  = 1'b0;
    logic       vs  = 1'b0;
    logic       trig = 1'b0;
    logic       done1, done2;

    histogram_axi_banked_if ax1();
    histogram_axi_banked_if ax2();

    histogram_axi_banked #(.PIX_W(8), .BIN_BITS(8), .CNT_W(24)) dut1 (
        .clk(clk), .rst(rst), .y_i(y), .dv_i(dv), .vs_i(vs),
        .cpu_trigger(trig), .cpu_signal_done(done1), .axi(ax1));

    histogram_axi_banked #(.PIX_W(8), .BIN_BITS(4), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .y_i(y), .dv_i(dv), .vs_i(vs),
        .cpu_trigger(trig), .cpu_signal_done(done2), .axi(ax2));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned mb [256];
    int unsigned mb2 [16];
    int unsigned mt, mt2;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mb[i] = 0;
        for (int i = 0; i < 16; i++) mb2[i] = 0;
        mt = 0;
        mt2 = 0;
    endtask

    task automatic px(input logic [7:0] v, input logic d);
        y  = v;
        dv = d;
        if (d) begin
            if (mb[v] < 32'hFFFFFF) mb[v]++;
            if (mb2[v >> 4] < 15) mb2[v >> 4]++;
            mt++;
            mt2++;
        end
        @(negedge clk);
    endtask

    task automatic arm_frame();
        repeat (262) @(negedge clk);
        vs = 1'b1;
        repeat (2) @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        model_clear();
    endtask

    task automatic start_frame();
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        arm_frame();
    endtask

    task automatic end_frame(output int n);
        dv = 1'b0;
        vs = 1'b1;
        n  = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vs = 1'b0;
        @(negedge clk);
    endtask

    task automatic axi_read(input bit sel, input logic [31:0] addr,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        if (sel) begin ax2.araddr = addr; ax2.arvalid = 1'b1; end
        else     begin ax1.araddr = addr; ax1.arvalid = 1'b1; end
        n = 0;
        while (!(sel ? ax2.arready : ax1.arready) && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        ax1.arvalid = 1'b0;
        ax2.arvalid = 1'b0;
        while (!(sel ? ax2.rvalid : ax1.rvalid) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL axi_timeout addr=%h no response within 20 cycles", addr);
        end
        data = sel ? ax2.rdata : ax1.rdata;
        resp = sel ? ax2.rresp : ax1.rresp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        d = {ax1.rdata[31:1], ax1.arready};
        checks++; if (ax1.arready !== 1'b1) begin failures++; $display("FAIL reset_arready got=%b exp=1", ax1.arready); end
        checks++; if (ax1.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", ax1.rvalid); end
        checks++; if (ax1.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", ax1.rdata); end
        checks++; if (ax1.rresp !== 2'b00) begin failures++; $display("FAIL reset_rresp got=%b exp=00", ax1.rresp); end
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done1); end
        rst = 1'b0;
        @(negedge clk);
        ax1.araddr  = 32'h404;
        ax1.arvalid = 1'b1;
        @(negedge clk);
        ax1.arvalid = 1'b0;
        checks++; if (ax1.arready !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", ax1.arready); end
        @(negedge clk);
        checks++; if (ax1.rvalid !== 1'b1) begin failures++; $display("FAIL rvalid_n2 got=%b exp=1", ax1.rvalid); end
        checks++; if (ax1.rdata !== 32'h0 || ax1.rresp !== 2'b00)
            begin failures++; $display("FAIL reset_status got=%h/%b exp=0/00", ax1.rdata, ax1.rresp); end
        @(negedge clk);
        checks++; if (ax1.arready !== 1'b1 || ax1.rvalid !== 1'b0)
            begin failures++; $display("FAIL ar_return got=%b/%b exp=1/0", ax1.arready, ax1.rvalid); end
    endtask

    task automatic test_frame();
        int n;
        logic [31:0] d;
        logic [1:0] r;
        start_frame();
        repeat (1000) px(8'h37, 1'b1);
        repeat (24) px(8'hFF, 1'b1);
        end_frame(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL done_latency got=%0d exp=4", n); end
        checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL frame_done got=%b exp=1", done1); end
        for (int i = 0; i < 256; i++) begin
            axi_read(0, 32'(i) << 2, d, r);
            checks++;
            if (d !== mb[i] || r !== 2'b00) begin failures++; $display("FAIL frame_bin[%0d] got=%0d/%b exp=%0d/00", i, d, r, mb[i]); end
        end
        axi_read(0, 32'h400, d, r);
        checks++; if (d !== 32'd1024) begin failures++; $display("FAIL frame_total got=%0d exp=1024", d); end
        axi_read(0, 32'h404, d, r);
        checks++; if (d !== 32'h1 || r !== 2'b00) begin failures++; $display("FAIL frame_status got=%h/%b exp=1/00", d, r); end
    endtask

    task automatic test_random();
        int n;
        logic [31:0] d;
        logic [1:0] r;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL done_fall got=%b exp=0", done1); end
        arm_frame();
        repeat (600) px(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        end_frame(n);
        checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL rand_done got=%b exp=1 after %0d", done1, n); end
        for (int i = 0; i < 256; i++) begin
            axi_read(0, 32'(i) << 2, d, r);
            checks++;
            if (d !== mb[i]) begin failures++; $display("FAIL rand_bin[%0d] got=%0d exp=%0d", i, d, mb[i]); end
        end
        axi_read(0, 32'h400, d, r);
        checks++; if (d !== mt) begin failures++; $display("FAIL rand_total got=%0d exp=%0d", d, mt); end
        for (int i = 0; i < 16; i++) begin
            axi_read(1, 32'(i) << 2, d, r);
            checks++;
            if (d !== mb2[i]) begin failures++; $display("FAIL rand_sat_bin[%0d] got=%0d exp=%0d", i, d, mb2[i]); end
        end
        axi_read(1, 32'h40, d, r);
        checks++; if (d !== mt2) begin failures++; $display("FAIL rand_sat_total got=%0d exp=%0d", d, mt2); end
    endtask

    task automatic test_forward();
        int n;
        logic [31:0] d;
        logic [1:0] r;
        start_frame();
        repeat (256) begin
            px(8'hA5, 1'b1);
            px(8'hA5, 1'b1);
            px(8'hA5, 1'b0);
            px(8'hA5, 1'b1);
        end
        end_frame(n);
        axi_read(0, 32'hA5 << 2, d, r);
        checks++; if (d !== 32'd768) begin failures++; $display("FAIL fwd_bin got=%0d exp=768", d); end
        axi_read(0, 32'hA4 << 2, d, r);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL fwd_lo got=%0d exp=0", d); end
        axi_read(0, 32'hA6 << 2, d, r);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL fwd_hi got=%0d exp=0", d); end
        axi_read(0, 32'h400, d, r);
        checks++; if (d !== 32'd768) begin failures++; $display("FAIL fwd_total got=%0d exp=768", d); end
    endtask

    task automatic test_saturate();
        int n;
        logic [31:0] d;
        logic [1:0] r;
        start_frame();
        repeat (20) px(8'h55, 1'b1);
        end_frame(n);
        axi_read(1, 32'h14, d, r);
        checks++; if (d !== 32'd15) begin failures++; $display("FAIL sat_bin got=%0d exp=15", d); end
        axi_read(1, 32'h40, d, r);
        checks++; if (d !== 32'd20) begin failures++; $display("FAIL sat_total got=%0d exp=20", d); end
        axi_read(0, 32'h55 << 2, d, r);
        checks++; if (d !== 32'd20) begin failures++; $display("FAIL wide_bin got=%0d exp=20", d); end
    endtask

    task automatic test_slverr();
        int n;
        logic [31:0] d;
        logic [1:0] r;
        start_frame();
        repeat (50) px(8'($urandom_range(0, 255)), 1'b1);
        dv = 1'b0;
        repeat (3) @(negedge clk);
        axi_read(0, 32'h400, d, r);
        checks++; if (d !== mt || r !== 2'b00) begin failures++; $display("FAIL accum_total got=%0d/%b exp=%0d/00", d, r, mt); end
        axi_read(0, 32'h404, d, r);
        checks++; if (d !== 32'h6 || r !== 2'b00) begin failures++; $display("FAIL accum_status got=%h/%b exp=6/00", d, r); end
        ax1.rready  = 1'b0;
        ax1.araddr  = 32'h0;
        ax1.arvalid = 1'b1;
        @(negedge clk);
        ax1.arvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ax1.rvalid !== 1'b1 || ax1.rresp !== 2'b10 || ax1.rdata !== 32'h0)
                begin failures++; $display("FAIL slverr_hold[%0d] got=%b/%b/%h exp=1/10/0", i, ax1.rvalid, ax1.rresp, ax1.rdata); end
            @(negedge clk);
        end
        ax1.rready = 1'b1;
        @(negedge clk);
        checks++; if (ax1.rvalid !== 1'b0) begin failures++; $display("FAIL slverr_release got=%b exp=0", ax1.rvalid); end
        end_frame(n);
        checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL slverr_done got=%b exp=1", done1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0] r;
        for (int k = 0; k < 2; k++) begin
            start_frame();
            repeat (10) px(8'h12, 1'b1);
            dv = 1'b0;
            ax1.araddr  = 32'h400;
            ax1.arvalid = 1'b1;
            @(negedge clk);
            ax1.arvalid = 1'b0;
            rst = 1'b1;
            #1;
            checks++; if (ax1.arready !== 1'b1 || ax1.rvalid !== 1'b0 || done1 !== 1'b0)
                begin failures++; $display("FAIL midrst_outputs got=%b/%b/%b exp=1/0/0", ax1.arready, ax1.rvalid, done1); end
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
            checks++; if (ax1.rvalid !== 1'b0) begin failures++; $display("FAIL midrst_dropped got=%b exp=0", ax1.rvalid); end
            axi_read(0, 32'h404, d, r);
            checks++; if (d !== 32'h0) begin failures++; $display("FAIL midrst_status got=%h exp=0", d); end
            trig = 1'b1;
            @(negedge clk);
            trig = 1'b0;
            repeat (254 + k) @(negedge clk);
            axi_read(0, 32'h404, d, r);
            checks++;
            if (d !== (k == 0 ? 32'h2 : 32'h4))
                begin failures++; $display("FAIL clear_len[%0d] got=%h exp=%h", k, d, (k == 0 ? 32'h2 : 32'h4)); end
        end
    endtask

    initial begin
        ax1.araddr = '0; ax1.arvalid = 1'b0; ax1.rready = 1'b1;
        ax2.araddr = '0; ax2.arvalid = 1'b0; ax2.rready = 1'b1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_frame();
        test_random();
        test_forward();
        test_saturate();
        test_slverr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
